// File: rtl/hub75_line_receiver.sv
// HUB75 receive side: deserializes shifted lines into a double-buffered store, then replays each latched line as a valid/ready pixel stream (row check under HUB75_RX_ROWCHK_EN).
// First pixel is valid the cycle after the LAT sample edge; all pixel outputs hold while pix_ready is low, and a good line arriving while the store is still streaming is dropped.
module hub75_line_receiver #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                A,
    input  logic                B,
    input  logic                C,
    input  logic                D,
    input  logic                R0,
    input  logic                G0,
    input  logic                B0,
    input  logic                R1,
    input  logic                G1,
    input  logic                B1,
    input  logic                OE,
    input  logic                LAT,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [5:0]          pix_data,
    output logic [5:0]          pix_col,
    output logic [ROW_BITS-1:0] pix_row,
    output logic                pix_last,
    output logic                line_err,
    output logic                overrun,
    output logic                row_err
);

    typedef enum logic {R_IDLE = 1'b0, R_SEND = 1'b1} rd_state_t;

    rd_state_t           r_state;
    rd_state_t           w_state_nxt;
    logic [6:0]          r_wr_col;
    logic [6:0]          r_rd_col;
    logic                r_extra;
    logic                r_wr_bank;
    logic [5:0]          r_mem [0:1][0:63];
    logic [ROW_BITS-1:0] r_row;
    logic                r_line_err;
    logic                r_overrun;

    logic                w_rd_bank;
    logic                w_sample;
    logic                w_wr_room;
    logic                w_good;
    logic                w_accept;
    logic                w_accept_last;
    logic                w_commit;
    logic [ROW_BITS-1:0] w_row;
    logic [5:0]          w_pix;

    assign w_row         = ROW_BITS'({D, C, B, A});
    assign w_pix         = {R0, G0, B0, R1, G1, B1};
    assign w_rd_bank     = ~r_wr_bank;
    assign w_sample      = OE & ~LAT;
    assign w_wr_room     = (r_wr_col < 7'(COLS));
    assign w_good        = LAT & (r_wr_col == 7'(COLS)) & ~r_extra;
    assign w_accept      = pix_valid & pix_ready;
    assign w_accept_last = w_accept & pix_last;
    // The read side counts as free when its final beat leaves on this very edge.
    assign w_commit      = w_good & ((r_state == R_IDLE) | w_accept_last);

    assign pix_valid = (r_state == R_SEND);
    assign pix_last  = pix_valid & (r_rd_col == 7'(COLS - 1));
    assign pix_data  = pix_valid ? r_mem[w_rd_bank][r_rd_col[5:0]] : 6'd0;
    assign pix_col   = r_rd_col[5:0];
    assign pix_row   = r_row;
    assign line_err  = r_line_err;
    assign overrun   = r_overrun;

    always_ff @(posedge clk) begin
        if (w_sample && w_wr_room) begin
            r_mem[r_wr_bank][r_wr_col[5:0]] <= w_pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_col  <= 7'd0;
            r_extra   <= 1'b0;
            r_wr_bank <= 1'b0;
        end else if (LAT) begin
            r_wr_col <= 7'd0;
            r_extra  <= 1'b0;
            if (w_commit) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end else if (w_sample) begin
            if (w_wr_room) begin
                r_wr_col <= r_wr_col + 7'd1;
            end else begin
                r_extra <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            R_IDLE: begin
                if (w_commit) begin
                    w_state_nxt = R_SEND;
                end
            end
            R_SEND: begin
                if (w_commit) begin
                    w_state_nxt = R_SEND;
                end else if (w_accept_last) begin
                    w_state_nxt = R_IDLE;
                end
            end
            default: w_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_col   <= 7'd0;
            r_row      <= '0;
            r_line_err <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_line_err <= LAT & ~w_good;
            r_overrun  <= w_good & ~w_commit;
            if (w_commit) begin
                r_rd_col <= 7'd0;
                r_row    <= w_row;
            end else if (w_accept) begin
                r_rd_col <= w_accept_last ? 7'd0 : (r_rd_col + 7'd1);
            end
        end
    end

`ifdef HUB75_RX_ROWCHK_EN
    // r_row only moves on commit, so it already holds the previous committed row.
    logic r_have_prev;
    logic r_row_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_have_prev <= 1'b0;
            r_row_err   <= 1'b0;
        end else begin
            r_row_err <= 1'b0;
            if (w_commit) begin
                r_have_prev <= 1'b1;
                r_row_err   <= r_have_prev & (w_row != ROW_BITS'(r_row + 1'b1));
            end
        end
    end

    assign row_err = r_row_err;
`else
    assign row_err = 1'b0;
`endif

endmodule

// File: doc/hub75_line_receiver.md
# hub75_line_receiver

Receive side of the team's HUB75 LED-matrix link. The block samples the panel-side signal bundle (row address A–D, dual-half RGB R0/G0/B0/R1/G1/B1, OE, LAT) and deserializes each shifted line into a double-buffered line store. After each latch it replays the line as a valid/ready pixel stream tagged with row and column. It sits in the loopback/verification path beside the matrix driver and gives monitors and checkers a cycle-accurate view of what the panel would display.

## Interface
- COLS, 64, pixels shifted per line; legal range 2–64.
- ROW_BITS, 4, width of the row address {D,C,B,A}.
- clk  in  1  system clock; all inputs are synchronous to it.
- rst_n  in  1  asynchronous, active-low reset.
- A, B, C, D  in  1 each  row address; row = {D,C,B,A}.
- R0, G0, B0, R1, G1, B1  in  1 each  upper-half and lower-half pixel colour.
- OE  in  1  high while pixel data is being shifted.
- LAT  in  1  latch strobe; ends a line.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accept.
- pix_data  out  6  {R0,G0,B0,R1,G1,B1} of the current pixel.
- pix_col  out  6  column index, 0..COLS-1.
- pix_row  out  ROW_BITS  row address captured at latch.
- pix_last  out  1  high with pix_valid on column COLS-1.
- line_err  out  1  one-cycle pulse when a latch sees a column count other than COLS.
- overrun  out  1  one-cycle pulse when a good line is dropped because the read side is busy.
- row_err  out  1  one-cycle pulse on a row-sequence error (see Configuration).

## Operation
- Write side:
  - A pixel is sampled on every clk edge where OE=1 and LAT=0. The sample is written to the write bank at wr_col, then wr_col increments.
  - wr_col saturates at COLS. Pixels beyond COLS are discarded and mark the line bad.
- Latch cycle (LAT=1; OE is don't-care and no pixel is sampled):
  - If wr_col==COLS and no extra pixels were seen, the line is good:
    - If the read FSM is R_IDLE, the line commits: banks swap, {D,C,B,A} is captured into pix_row, and the read FSM enters R_SEND.
    - If the read FSM is R_SEND, overrun pulses and the line is dropped. The write bank is reused.
  - Otherwise line_err pulses and the line is dropped.
  - wr_col clears to 0 in either case.
- Read FSM:
  - R_IDLE: pix_valid=0.
  - R_IDLE → R_SEND on commit.
  - R_SEND: pix_valid=1, and pix_data is the read bank at rd_col. On pix_valid&&pix_ready, rd_col increments.
  - On acceptance of pix_last, rd_col returns to 0 and the FSM goes to R_IDLE.
- Simultaneous events:
  - Acceptance of pix_last and a good latch in the same cycle count as a commit, not an overrun. R_SEND restarts at column 0 with no idle cycle.
  - Consecutive LAT cycles: the second sees wr_col=0, which is a line_err (a zero-length line).
- Backpressure:
  - pix_data, pix_col, pix_row and pix_last hold stable while pix_valid=1 and pix_ready=0.
  - pix_valid never drops without acceptance.
- Arithmetic: wr_col and rd_col are 7 bits internally so that the value COLS=64 is representable. pix_col is the low 6 bits of rd_col.

## Timing
- Reset values: pix_valid=0, pix_data=0, pix_col=0, pix_row=0, pix_last=0, line_err=0, overrun=0, row_err=0. Read FSM is R_IDLE; wr_col=0 and rd_col=0; the write bank is bank 0.
- Reset mid-line or mid-stream: all captured and pending data is discarded and the stream aborts without completing.
- Latency: pix_valid rises on the edge after the edge that samples LAT.
  - Column 0 is presented first.
  - With pix_ready held at 1, one pixel is delivered per cycle, so a line drains in COLS cycles.
- line_err, overrun and row_err are registered. Each is high for exactly the cycle after the LAT sample edge.
- A new line can be captured into the write bank while the previous line streams out.

## Configuration
- HUB75_RX_ROWCHK_EN:
  - When defined, each committed row is compared with (previous committed row + 1) mod 2^ROW_BITS. A mismatch pulses row_err, registered in the same cycle the line commits.
  - The first commit after reset is exempt.
  - The line is still delivered.
- When not defined, row_err is tied to 0 and no compare logic is built.

## Test plan
- Good line with ready held high: shift 64 pixels with pixel n = n[5:0] while OE=1, then LAT with row=5.
  - Expected: pix_valid rises 1 cycle after LAT; 64 beats with pix_col 0..63 and pix_data=n.
  - pix_row=5 on every beat; pix_last only on beat 63.
  - No error pulses.
- Short and long lines: shift 63 pixels then LAT → one line_err pulse and no pix_valid. Shift 65 pixels then LAT → one line_err pulse and no pix_valid.
- Backpressure: good line, then pix_ready toggled 1,0,0,1,… → every beat held stable while stalled. All 64 beats arrive in order.
- Overrun: with pix_ready=0, send two good lines (rows 1 and 2) → line 1 streams once ready rises; overrun pulses at line 2's LAT; row 2 is never emitted.
- Simultaneous case: pix_last accepted in the same cycle as a good LAT for row 3 → no overrun, and the next cycle shows pix_valid=1, pix_col=0, pix_row=3.
- Row check and reset: with HUB75_RX_ROWCHK_EN defined, send rows 0,1,3 → row_err pulses on the row-3 commit. Assert rst_n=0 mid-stream → all outputs return to their reset values.
